data_mem_arbiter: RTL and testbench

Shares the single data-memory port (one-cycle read latency, byte write enables) between NUM_REQ bus masters, e.g. the MIPS CPU and a future DMA/UART engine. The block uses a req/ack handshake per requester, round-robin arbitration and optional locked bursts. It sits between the masters and the data Memory instance, replacing the direct CPU-to-memory wiring. It drives the memory's ce, wbe, address and data_in, and returns memory data_out to the winner.

---
 rtl/data_mem_arbiter_if.sv | 36 +++
 rtl/data_mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - requester and data-memory signal bundle for data_mem_arbiter
interface data_mem_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32
);
  // Requester side
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            lock;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*4-1:0]          req_wbe;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            ack;
  logic [DATA_WIDTH-1:0]         rdata;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;

  // Data-memory side
  logic                          mem_ce;
  logic [3:0]                    mem_wbe;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0]         mem_wdata;
  logic [DATA_WIDTH-1:0]         mem_rdata;

  // Arbiter view
  modport slave (
    input  req, lock, req_addr, req_wbe, req_wdata, mem_rdata,
    output ack, rdata, grant, busy, mem_ce, mem_wbe, mem_addr, mem_wdata
  );

  // Requesters plus memory view
  modport master (
    output req, lock, req_addr, req_wbe, req_wdata, mem_rdata,
    input  ack, rdata, grant, busy, mem_ce, mem_wbe, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - shares the data-memory port between NUM_REQ masters; DATA_MEM_ARB_FIXED_PRIO_EN selects fixed priority
module data_mem_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant_q, grant_nxt;
  logic [IDX_W-1:0]   gnt_idx, gnt_idx_nxt;
  logic [3:0]         beat_cnt, beat_nxt;
  logic [IDX_W-1:0]   arb_ptr;
  logic               win_valid;
  logic [IDX_W-1:0]   win_idx;
  logic               burst_go;

`ifndef DATA_MEM_ARB_FIXED_PRIO_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]   rr_ptr, rr_nxt;
  logic [IDX_W-1:0]   after_g;

  // The index just past the current owner is where the next search starts
  assign after_g = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
  // In DONE the search already starts past the owner, so it only wins again when nobody else asks
  assign arb_ptr = (state == DONE) ? after_g : rr_ptr;
`else
  // Fixed priority: always search from index 0, so the lowest pending index wins
  assign arb_ptr = '0;
`endif

  // The owner keeps the port only while it asks for a lock and has burst beats left
  assign burst_go = bus.req[gnt_idx] && bus.lock[gnt_idx] && (beat_cnt < 4'(MAX_BURST));

  // Find the first asserted request at or after arb_ptr, wrapping modulo NUM_REQ
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[(int'(arb_ptr) + i) % NUM_REQ]) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'((int'(arb_ptr) + i) % NUM_REQ);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Ownership, burst counter and rotation pointer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q  <= '0;
      gnt_idx  <= '0;
      beat_cnt <= '0;
`ifndef DATA_MEM_ARB_FIXED_PRIO_EN
      rr_ptr   <= '0;
`endif
    end else begin
      grant_q  <= grant_nxt;
      gnt_idx  <= gnt_idx_nxt;
      beat_cnt <= beat_nxt;
`ifndef DATA_MEM_ARB_FIXED_PRIO_EN
      rr_ptr   <= rr_nxt;
`endif
    end
  end

  // Next-state and next-ownership decisions
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant_q;
    gnt_idx_nxt = gnt_idx;
    beat_nxt    = beat_cnt;
`ifndef DATA_MEM_ARB_FIXED_PRIO_EN
    rr_nxt      = rr_ptr;
`endif
    case (state)
      IDLE: begin
        if (win_valid) begin
          state_nxt   = ACCESS;
          grant_nxt   = NUM_REQ'(1) << win_idx;
          gnt_idx_nxt = win_idx;
          beat_nxt    = 4'd1;
        end
      end
      ACCESS: begin
        state_nxt = DONE;
      end
      DONE: begin
        if (burst_go) begin
          state_nxt = ACCESS;
          beat_nxt  = beat_cnt + 4'd1;
        end else begin
`ifndef DATA_MEM_ARB_FIXED_PRIO_EN
          rr_nxt = after_g;
`endif
          if (win_valid) begin
            state_nxt   = ACCESS;
            grant_nxt   = NUM_REQ'(1) << win_idx;
            gnt_idx_nxt = win_idx;
            beat_nxt    = 4'd1;
          end else begin
            state_nxt = IDLE;
            grant_nxt = '0;
            beat_nxt  = 4'd0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // Memory strobes in ACCESS, completion pulse and read data in DONE
  always_comb begin
    bus.mem_ce    = 1'b0;
    bus.mem_wbe   = 4'b0000;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.ack       = '0;
    bus.rdata     = '0;
    bus.busy      = 1'b0;
    case (state)
      ACCESS: begin
        bus.mem_ce    = 1'b1;
        bus.mem_wbe   = bus.req_wbe[gnt_idx*4 +: 4];
        bus.mem_addr  = bus.req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        bus.mem_wdata = bus.req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        bus.busy      = 1'b1;
      end
      DONE: begin
        bus.ack   = grant_q;
        bus.rdata = bus.mem_rdata;
        bus.busy  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.grant = grant_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - directed self-checking bench for data_mem_arbiter
module tb_data_mem_arbiter;
  localparam int NR = 2;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  // Two-word memory model: 0x10 and 0x20 are the only words touched
  logic [31:0] w10 = 32'hDEADBEEF;
  logic [31:0] w20 = 32'h11223344;

  always #5 clk = ~clk;

  data_mem_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  data_mem_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // One-cycle read latency memory with byte write enables
  always @(posedge clk) begin
    if (bus.mem_ce) begin
      if (bus.mem_addr == 30'h10) begin
        bus.mem_rdata <= w10;
        w10 <= merge(w10, bus.mem_wdata, bus.mem_wbe);
      end else if (bus.mem_addr == 30'h20) begin
        bus.mem_rdata <= w20;
        w20 <= merge(w20, bus.mem_wdata, bus.mem_wbe);
      end else begin
        bus.mem_rdata <= 32'h0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One access: ACCESS cycle checks, then DONE cycle checks; returns at the DONE negedge
  task automatic access(input string tag, input logic [1:0] g, input logic [29:0] addr,
                        input logic [3:0] wbe, input logic [31:0] wdata,
                        input bit chk_rd, input logic [31:0] rd);
    @(negedge clk);
    chk({tag, " grant"},    bus.grant,    g);
    chk({tag, " mem_ce"},   bus.mem_ce,   1'b1);
    chk({tag, " mem_addr"}, bus.mem_addr, addr);
    chk({tag, " mem_wbe"},  bus.mem_wbe,  wbe);
    chk({tag, " busy"},     bus.busy,     1'b1);
    if (wbe != 4'b0000) chk({tag, " mem_wdata"}, bus.mem_wdata, wdata);
    @(negedge clk);
    chk({tag, " ack"},      bus.ack,      g);
    chk({tag, " done_ce"},  bus.mem_ce,   1'b0);
    if (chk_rd) chk({tag, " rdata"}, bus.rdata, rd);
  endtask

  function automatic logic [29:0] addr_of(input logic [1:0] g);
    return (g == 2'b01) ? 30'h10 : 30'h20;
  endfunction

  function automatic logic [31:0] rd_of(input logic [1:0] g);
    return (g == 2'b01) ? 32'hDEADBEEF : 32'h1122ABCD;
  endfunction

  initial begin
    logic [1:0] cont_exp  [4];
    logic [1:0] burst_exp [6];
`ifdef DATA_MEM_ARB_FIXED_PRIO_EN
    cont_exp  = '{2'b01, 2'b01, 2'b01, 2'b01};
    burst_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
`else
    cont_exp  = '{2'b01, 2'b10, 2'b01, 2'b10};
    burst_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
`endif

    bus.req       = '0;
    bus.lock      = '0;
    bus.req_addr  = {30'h20, 30'h10};
    bus.req_wbe   = '0;
    bus.req_wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst grant",     bus.grant,     2'b00);
    chk("rst ack",       bus.ack,       2'b00);
    chk("rst busy",      bus.busy,      1'b0);
    chk("rst mem_ce",    bus.mem_ce,    1'b0);
    chk("rst mem_wbe",   bus.mem_wbe,   4'b0000);
    chk("rst mem_addr",  bus.mem_addr,  30'h0);
    chk("rst mem_wdata", bus.mem_wdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle grant", bus.grant, 2'b00);

    // Single read by requester 0
    bus.req = 2'b01;
    access("read", 2'b01, 30'h10, 4'b0000, 32'h0, 1'b1, 32'hDEADBEEF);
    bus.req = 2'b00;
    @(negedge clk);
    chk("post read grant", bus.grant, 2'b00);
    chk("post read busy",  bus.busy,  1'b0);

    // Half-word write by requester 1
    bus.req_wbe   = {4'b0011, 4'b0000};
    bus.req_wdata = {32'h0000ABCD, 32'h0};
    bus.req       = 2'b10;
    access("write", 2'b10, 30'h20, 4'b0011, 32'h0000ABCD, 1'b0, 32'h0);
    bus.req       = 2'b00;
    bus.req_wbe   = '0;
    bus.req_wdata = '0;
    @(negedge clk);

    // Readback of the written word through requester 0
    bus.req_addr = {30'h20, 30'h20};
    bus.req      = 2'b01;
    access("readback", 2'b01, 30'h20, 4'b0000, 32'h0, 1'b1, 32'h1122ABCD);
    bus.req      = 2'b00;
    bus.req_addr = {30'h20, 30'h10};
    @(negedge clk);

    // Fresh reset, then both request continuously
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      access($sformatf("contend%0d", k), cont_exp[k], addr_of(cont_exp[k]),
             4'b0000, 32'h0, 1'b1, rd_of(cont_exp[k]));
      if (k == 3) bus.req = 2'b10;
    end
    access("req1 only", 2'b10, 30'h20, 4'b0000, 32'h0, 1'b1, 32'h1122ABCD);
    bus.req = 2'b00;
    @(negedge clk);
    chk("post contend busy", bus.busy, 1'b0);

    // Locked burst by requester 0 with requester 1 waiting
    bus.lock = 2'b01;
    bus.req  = 2'b11;
    for (int k = 0; k < 6; k++) begin
      access($sformatf("burst%0d", k), burst_exp[k], addr_of(burst_exp[k]),
             4'b0000, 32'h0, 1'b1, rd_of(burst_exp[k]));
    end

    // Reset asserted in the middle of an ACCESS cycle
    @(negedge clk);
    chk("midburst ce before rst", bus.mem_ce, 1'b1);
    rst = 1'b0;
    #1;
    chk("midburst rst mem_ce", bus.mem_ce, 1'b0);
    chk("midburst rst grant",  bus.grant,  2'b00);
    chk("midburst rst ack",    bus.ack,    2'b00);
    chk("midburst rst busy",   bus.busy,   1'b0);
    bus.req  = 2'b00;
    bus.lock = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post rst idle grant",  bus.grant,  2'b00);
    chk("post rst idle mem_ce", bus.mem_ce, 1'b0);
    chk("post rst idle busy",   bus.busy,   1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
